// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding and default widths for the MAC sequencer
package mac_seq_pkg;

    localparam int MAC_DATA_W = 8;
    localparam int MAC_ACC_W  = 16;
    localparam int MAC_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_seq_state_e;

endpackage

// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - operand pair stream between an operand source and the MAC sequencer
interface mac_seq_if #(
    parameter int DATA_W = mac_seq_pkg::MAC_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              add_sub;

    modport master (
        output in_valid,
        output A,
        output B,
        output add_sub,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  add_sub,
        output in_ready
    );
endinterface

// File: rtl/mac_seq_datapath.sv
// rtl/mac_seq_datapath.sv - operand stage, multiplier register and accumulator; MAC_SEQ_SATURATE_EN selects clamping
module mac_seq_datapath
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int ACC_W  = MAC_ACC_W
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              add_sub,
    output logic              op_pending,
    output logic [ACC_W-1:0]  RES,
    output logic              overflow
);

    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic                op_valid_q;
    logic                op_add_q;
    logic [2*DATA_W-1:0] mult_q;
    logic                mult_valid_q;
    logic                mult_add_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    prod_ext;

    // Valid bits are flushed on a new job so nothing from an aborted job can land.
    always_ff @(posedge CLK) begin
        if (!reset_n || clear) begin
            op_valid_q   <= 1'b0;
            mult_valid_q <= 1'b0;
        end else begin
            op_valid_q   <= push;
            mult_valid_q <= op_valid_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_add_q   <= 1'b0;
            mult_q     <= '0;
            mult_add_q <= 1'b0;
        end else begin
            if (push) begin
                op_a_q   <= A;
                op_b_q   <= B;
                op_add_q <= add_sub;
            end
            if (op_valid_q) begin
                mult_q     <= (2*DATA_W)'(op_a_q) * (2*DATA_W)'(op_b_q);
                mult_add_q <= op_add_q;
            end
        end
    end

    assign prod_ext = ACC_W'(mult_q);

`ifdef MAC_SEQ_SATURATE_EN
    logic [ACC_W:0] sum_w;
    logic [ACC_W:0] diff_w;
    logic           ovf_d;
    logic           ovf_q;

    // One extra bit catches carry on add and borrow on subtract.
    always_comb begin
        sum_w  = {1'b0, acc_q} + {1'b0, prod_ext};
        diff_w = {1'b0, acc_q} - {1'b0, prod_ext};
        acc_d  = acc_q;
        ovf_d  = 1'b0;
        if (mult_add_q) begin
            if (sum_w[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_w[ACC_W-1:0];
            end
        end else begin
            if (diff_w[ACC_W]) begin
                acc_d = '0;
                ovf_d = 1'b1;
            end else begin
                acc_d = diff_w[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n || clear) begin
            ovf_q <= 1'b0;
        end else if (mult_valid_q && ovf_d) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    always_comb begin
        acc_d = mult_add_q ? (acc_q + prod_ext) : (acc_q - prod_ext);
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!reset_n || clear) begin
            acc_q <= '0;
        end else if (mult_valid_q) begin
            acc_q <= acc_d;
        end
    end

    assign op_pending = op_valid_q;
    assign RES        = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - job FSM, remaining counter and handshake for the MAC datapath; MAC_SEQ_SATURATE_EN enables saturation
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int LEN_W  = MAC_LEN_W
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    mac_seq_if.slave         in_if,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] RES,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [LEN_W-1:0] remaining_q;
    logic             done_q;
    logic             accept_start;
    logic             handshake;
    logic             op_pending;

    assign accept_start   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign handshake      = (state_q == S_RUN) && in_if.in_valid;
    assign in_if.in_ready = (state_q == S_RUN);
    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = done_q;

    // The product in the mult register lands on the same edge that leaves DRAIN,
    // so only the operand stage has to be empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_start) begin
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (handshake && (remaining_q == LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!op_pending) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // A len=0 start from DONE re-enters DONE and must pulse again.
            done_q  <= (state_d == S_DONE) && ((state_q != S_DONE) || accept_start);
            if (accept_start) begin
                remaining_q <= len;
            end else if (handshake) begin
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    mac_seq_datapath #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_datapath (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .clear      (accept_start),
        .push       (handshake),
        .A          (in_if.A),
        .B          (in_if.B),
        .add_sub    (in_if.add_sub),
        .op_pending (op_pending),
        .RES        (RES),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;
    import mac_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] RES;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

`ifdef MAC_SEQ_SATURATE_EN
    localparam logic [15:0] UNDER_RES = 16'h0000;
    localparam logic        UNDER_OVF = 1'b1;
`else
    localparam logic [15:0] UNDER_RES = 16'hFFFF;
    localparam logic        UNDER_OVF = 1'b0;
`endif

    mac_seq_if #(.DATA_W(8)) in_if ();

    mac_seq_ctrl #(
        .DATA_W (8),
        .ACC_W  (16),
        .LEN_W  (8)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .start    (start),
        .len      (len),
        .in_if    (in_if),
        .busy     (busy),
        .done     (done),
        .RES      (RES),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic start_job(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic as);
        in_if.A        = a;
        in_if.B        = b;
        in_if.add_sub  = as;
        in_if.in_valid = 1'b1;
        tick();
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done !== 1'b1 && g < 40) begin
            tick();
            g++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (RES !== 16'd0) begin n_bad++; $display("FAIL reset_res: got %0d want 0", RES); end
        n_cmp++; if (in_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", in_if.in_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_job(8'd3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_run: got %b want 1", busy); end
        n_cmp++; if (in_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_run: got %b want 1", in_if.in_ready); end
        send_pair(8'd2, 8'd3, 1'b1);
        send_pair(8'd4, 8'd5, 1'b1);
        send_pair(8'd1, 8'd6, 1'b0);
        n_cmp++; if (in_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drain: got %b want 0", in_if.in_ready); end
        wait_done();
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL basic_latency: got %0d want 6", cyc); end
        n_cmp++; if (RES !== 16'd20) begin n_bad++; $display("FAIL basic_res: got %0d want 20", RES); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_cmp++; if (RES !== 16'd20) begin n_bad++; $display("FAIL basic_res_held: got %0d want 20", RES); end
    endtask

    task automatic test_bubbles();
        start_job(8'd3);
        send_pair(8'd2, 8'd3, 1'b1);
        tick();
        tick();
        send_pair(8'd4, 8'd5, 1'b1);
        send_pair(8'd1, 8'd6, 1'b0);
        wait_done();
        n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL bubble_latency: got %0d want 8", cyc); end
        n_cmp++; if (RES !== 16'd20) begin n_bad++; $display("FAIL bubble_res: got %0d want 20", RES); end
    endtask

    task automatic test_len_zero();
        start_job(8'd0);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL len0_done: got %b want 1", done); end
        n_cmp++; if (RES !== 16'd0) begin n_bad++; $display("FAIL len0_res: got %0d want 0", RES); end
        n_cmp++; if (in_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL len0_ready: got %b want 0", in_if.in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy: got %b want 0", busy); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL len0_done_pulse: got %b want 0", done); end
        n_cmp++; if (in_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL len0_ready_after: got %b want 0", in_if.in_ready); end
    endtask

    task automatic test_underflow();
        start_job(8'd1);
        send_pair(8'd1, 8'd1, 1'b0);
        wait_done();
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL under_latency: got %0d want 4", cyc); end
        n_cmp++; if (RES !== UNDER_RES) begin n_bad++; $display("FAIL under_res: got %h want %h", RES, UNDER_RES); end
        n_cmp++; if (overflow !== UNDER_OVF) begin n_bad++; $display("FAIL under_ovf: got %b want %b", overflow, UNDER_OVF); end
        tick();
        n_cmp++; if (overflow !== UNDER_OVF) begin n_bad++; $display("FAIL under_ovf_sticky: got %b want %b", overflow, UNDER_OVF); end
    endtask

    task automatic test_start_ignored();
        start_job(8'd2);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ign_ovf_cleared: got %b want 0", overflow); end
        in_if.A        = 8'd1;
        in_if.B        = 8'd2;
        in_if.add_sub  = 1'b1;
        in_if.in_valid = 1'b1;
        start = 1'b1;
        len   = 8'd5;
        tick();
        start = 1'b0;
        in_if.in_valid = 1'b0;
        send_pair(8'd3, 8'd4, 1'b1);
        in_if.A        = 8'd7;
        in_if.B        = 8'd7;
        in_if.in_valid = 1'b1;
        n_cmp++; if (in_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL ign_ready_drop: got %b want 0", in_if.in_ready); end
        tick();
        in_if.in_valid = 1'b0;
        wait_done();
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL ign_latency: got %0d want 5", cyc); end
        n_cmp++; if (RES !== 16'd14) begin n_bad++; $display("FAIL ign_res: got %0d want 14", RES); end
    endtask

    task automatic test_mid_reset();
        logic seen_done;
        logic seen_ready;
        start_job(8'd4);
        send_pair(8'd5, 8'd5, 1'b1);
        send_pair(8'd6, 8'd6, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
        n_cmp++; if (RES !== 16'd0) begin n_bad++; $display("FAIL mrst_res: got %0d want 0", RES); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_done: got %b want 0", done); end
        n_cmp++; if (in_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL mrst_ready: got %b want 0", in_if.in_ready); end
        seen_done  = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
            if (in_if.in_ready === 1'b1) seen_ready = 1'b1;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL mrst_no_done: got %b want 0", seen_done); end
        n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL mrst_idle_ready: got %b want 0", seen_ready); end
        n_cmp++; if (RES !== 16'd0) begin n_bad++; $display("FAIL mrst_res_quiet: got %0d want 0", RES); end
        start_job(8'd1);
        send_pair(8'd3, 8'd3, 1'b1);
        wait_done();
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL mrst_fresh_latency: got %0d want 4", cyc); end
        n_cmp++; if (RES !== 16'd9) begin n_bad++; $display("FAIL mrst_fresh_res: got %0d want 9", RES); end
    endtask

    task automatic test_back_to_back();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_in_done: got %b want 1", done); end
        start_job(8'd1);
        n_cmp++; if (RES !== 16'd0) begin n_bad++; $display("FAIL b2b_cleared: got %0d want 0", RES); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
        send_pair(8'd2, 8'd2, 1'b1);
        wait_done();
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL b2b_latency: got %0d want 4", cyc); end
        n_cmp++; if (RES !== 16'd4) begin n_bad++; $display("FAIL b2b_res: got %0d want 4", RES); end
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.A        = 8'd0;
        in_if.B        = 8'd0;
        in_if.add_sub  = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_len_zero();
        test_underflow();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
